wishbone_fifo_device: RTL and testbench
=======================================

// Module: wishbone_fifo_device
// PURPOSE
// - Wishbone B4 classic (non-pipelined) device: the responder end of the wishbone_classic interface.
// - Backed by a single synchronous FIFO. A bus write pushes dat_i; a bus read pops into dat_o.
// - Gives controllers on the bus a buffered mailbox/loopback target.
// - Exercises ack/err/rty generation and programmable wait states for controller verification.
// PARAMETERS
// - DAT_WIDTH    8   bus/FIFO word width.
// - DEPTH        16  FIFO entries; power of two, >= 2.
// - WAIT_CYCLES  0   extra cycles between request sample and response, 0..255.
// - RTY_ON_STALL 1   1: write-when-full / read-when-empty ends with rty_o; 0: ends with err_o.
// PORTS
// - clk_i    in   1                  clock; all logic on posedge.
// - rst_i    in   1                  reset; synchronous, active-high.
// - cyc_i    in   1                  bus cycle in progress.
// - stb_i    in   1                  strobe; request = cyc_i && stb_i.
// - we_i     in   1                  1 = write (push), 0 = read (pop).
// - dat_i    in   DAT_WIDTH          write data.
// - ack_o    out  1                  normal termination.
// - err_o    out  1                  error termination (RTY_ON_STALL=0).
// - rty_o    out  1                  retry termination (RTY_ON_STALL=1).
// - dat_o    out  DAT_WIDTH          read data; valid only while ack_o && !we_i.
// - count_o  out  $clog2(DEPTH)+1    FIFO occupancy.
// - full_o   out  1                  count_o == DEPTH.
// - empty_o  out  1                  count_o == 0.
// BEHAVIOUR
// - Reset values: ack_o, err_o, rty_o = 0; dat_o = 0; count_o = 0; empty_o = 1; full_o = 0.
//   Reset also sets pointers to 0 and state to IDLE.
// - FSM IDLE/WAIT/RESP, all transitions registered.
//   - IDLE: on request, latch we_i/dat_i. Go to WAIT if WAIT_CYCLES>0, else commit and go to RESP.
//   - WAIT: count WAIT_CYCLES edges, then commit and go to RESP.
//     If cyc_i or stb_i drops while in WAIT: abort to IDLE. No push/pop, no termination.
//   - Commit: evaluate full/empty on the same edge that enters RESP.
//     Write & !full: push, ack. Read & !empty: pop into dat_o, ack. Otherwise: no FIFO change, rty (or err).
//   - RESP: exactly one of ack_o/err_o/rty_o is high for exactly one cycle, then IDLE.
//     Outputs return to 0 and dat_o returns to 0.
// - Latency: request first sampled in cycle t -> termination in cycle t+1+WAIT_CYCLES.
//   A held request is re-sampled in the IDLE cycle after RESP; back-to-back rate is one transfer per 2+WAIT_CYCLES cycles.
// - Request inputs are ignored in RESP; the device relies on controller stability until termination.
// - Never more than one termination bit high; never a termination without a sampled request.
// - FIFO: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count_o changes by ±1 only on a successful commit.
//   Push and pop never occur on the same edge (single bus).
// - Status: full_o/empty_o/count_o are registered and reflect state after the last commit edge.
// - Reset mid-transfer (rst_i high in WAIT or RESP): next cycle IDLE, outputs at reset values, FIFO emptied, no termination issued.
// STRUCTURE
// - wishbone_pkg: typedef enum logic [1:0] {WB_IDLE, WB_WAIT, WB_RESP} wb_dev_state_t;
//   typedef enum {WB_ACK, WB_ERR, WB_RTY} wb_term_t.
// - Sub-module sync_fifo #(DAT_WIDTH, DEPTH): storage, wrapping pointers, count/full/empty, push/pop ports.
//   Storage is read on the pop edge.
// - Top: bus FSM, wait counter, termination/dat_o registers. Formal hooks come from the wishbone_classic properties.
// TESTING
// - Reset, then write 0xA5 with W=0: ack_o in cycle t+1 only; count_o=1; empty_o=0.
//   Then read: ack_o at t+1 with dat_o=0xA5; count_o=0.
// - Write 0x01..0x10 (DEPTH=16): all ack, full_o=1. 17th write gets rty_o (RTY_ON_STALL=1), count_o stays 16.
//   Then 16 reads return 0x01..0x10 in order, with pointer wrap exercised.
// - Read on empty FIFO: with RTY_ON_STALL=0, err_o=1 for one cycle, ack_o=0, count_o=0, dat_o=0.
// - WAIT_CYCLES=3, write at t -> ack_o at t+4.
//   Repeat with cyc_i dropped at t+2: no termination, count_o unchanged.
// - Hold cyc_i/stb_i/we_i=1 across 3 writes: acks at t+1, t+3, t+5; count_o=3.
//   rst_i at t+2 of a W=3 transfer: no termination, count_o=0.

Source files
------------

// File: rtl/wishbone_pkg.sv
// Shared types for the Wishbone classic FIFO device: bus FSM states and termination kinds.
package wishbone_pkg;

    typedef enum logic [1:0] {WB_IDLE, WB_WAIT, WB_RESP} wb_dev_state_t;

    typedef enum {WB_ACK, WB_ERR, WB_RTY} wb_term_t;

    // Termination used when a write finds the FIFO full or a read finds it empty.
    function automatic wb_term_t stall_term(input bit rty_on_stall);
        return rty_on_stall ? WB_RTY : WB_ERR;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and occupancy count; the head word is read
// combinationally so the caller can capture it on the pop edge.
module sync_fifo #(
    parameter int unsigned DAT_WIDTH = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DAT_WIDTH-1:0]       wdata_i,
    output logic [DAT_WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DAT_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Push takes priority; the bus never asks for both on one edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o && !do_push;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            count_q  <= count_q + 1'b1;
        end else if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/wishbone_fifo_device.sv
// Wishbone B4 classic responder backed by a FIFO: writes push, reads pop, with optional
// wait states and a retry or error termination when the FIFO cannot accept/supply a word.
module wishbone_fifo_device
    import wishbone_pkg::*;
#(
    parameter int unsigned DAT_WIDTH    = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned WAIT_CYCLES  = 0,
    parameter int unsigned RTY_ON_STALL = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cyc_i,
    input  logic                       stb_i,
    input  logic                       we_i,
    input  logic [DAT_WIDTH-1:0]       dat_i,
    output logic                       ack_o,
    output logic                       err_o,
    output logic                       rty_o,
    output logic [DAT_WIDTH-1:0]       dat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam logic [7:0] WaitLast = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    wb_dev_state_t        state_q, state_d;
    logic [7:0]           wait_cnt_q, wait_cnt_d;
    logic                 we_q, we_d;
    logic [DAT_WIDTH-1:0] wdat_q, wdat_d;
    logic                 ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;

    logic                 req, commit, commit_we, push, pop;
    logic [DAT_WIDTH-1:0] commit_dat, fifo_rdata;
    wb_term_t             term;

    assign req        = cyc_i && stb_i;
    // A zero-wait commit happens in IDLE, before the request has been latched.
    assign commit_we  = (state_q == WB_IDLE) ? we_i : we_q;
    assign commit_dat = (state_q == WB_IDLE) ? dat_i : wdat_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        wdat_d     = wdat_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rty_d      = 1'b0;
        dat_d      = '0;
        commit     = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        term       = WB_ACK;

        case (state_q)
            WB_IDLE: begin
                if (req) begin
                    we_d       = we_i;
                    wdat_d     = dat_i;
                    wait_cnt_d = '0;
                    if (WAIT_CYCLES == 0) begin
                        commit = 1'b1;
                    end else begin
                        state_d = WB_WAIT;
                    end
                end
            end
            WB_WAIT: begin
                if (!req) begin
                    state_d = WB_IDLE;
                end else if (wait_cnt_q == WaitLast) begin
                    commit = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = WB_IDLE;
        endcase

        if (commit) begin
            state_d = WB_RESP;
            if (commit_we && !full_o) begin
                push = 1'b1;
            end else if (!commit_we && !empty_o) begin
                pop   = 1'b1;
                dat_d = fifo_rdata;
            end else begin
                term = stall_term(RTY_ON_STALL != 0);
            end
            unique case (term)
                WB_ACK:  ack_d = 1'b1;
                WB_ERR:  err_d = 1'b1;
                default: rty_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= WB_IDLE;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            wdat_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rty_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            wdat_q     <= wdat_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rty_q      <= rty_d;
            dat_q      <= dat_d;
        end
    end

    sync_fifo #(
        .DAT_WIDTH (DAT_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (commit_dat),
        .rdata_o (fifo_rdata),
        .count_o (count_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

    assign ack_o = ack_q;
    assign err_o = err_q;
    assign rty_o = rty_q;
    assign dat_o = dat_q;

endmodule

// File: tb/tb_wishbone_fifo_device.sv
// Directed bench for wishbone_fifo_device: three instances cover retry, error and wait-state
// configurations; each instance is selected by its own cyc line.
module tb_wishbone_fifo_device;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cyc;
    logic       stb, we;
    logic [7:0] dat;

    logic       ack [3];
    logic       err [3];
    logic       rty [3];
    logic [7:0] dout [3];
    logic [4:0] cnt [3];
    logic       full [3];
    logic       empty [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wishbone_fifo_device #(.DAT_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(0), .RTY_ON_STALL(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb), .we_i(we), .dat_i(dat),
        .ack_o(ack[0]), .err_o(err[0]), .rty_o(rty[0]), .dat_o(dout[0]),
        .count_o(cnt[0]), .full_o(full[0]), .empty_o(empty[0])
    );

    wishbone_fifo_device #(.DAT_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(0), .RTY_ON_STALL(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb), .we_i(we), .dat_i(dat),
        .ack_o(ack[1]), .err_o(err[1]), .rty_o(rty[1]), .dat_o(dout[1]),
        .count_o(cnt[1]), .full_o(full[1]), .empty_o(empty[1])
    );

    wishbone_fifo_device #(.DAT_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(3), .RTY_ON_STALL(1)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb), .we_i(we), .dat_i(dat),
        .ack_o(ack[2]), .err_o(err[2]), .rty_o(rty[2]), .dat_o(dout[2]),
        .count_o(cnt[2]), .full_o(full[2]), .empty_o(empty[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Termination bits packed as {ack, err, rty}.
    function automatic logic [2:0] term_of(input int s);
        return {ack[s], err[s], rty[s]};
    endfunction

    // One transfer: request held from cycle t, termination expected in cycle t+1+wc, then idle.
    task automatic xfer(input int s, input logic w, input logic [7:0] d, input int wc,
                        input logic [2:0] exp_term, input logic [7:0] exp_dat, input string tag);
        cyc[s] = 1'b1;
        stb    = 1'b1;
        we     = w;
        dat    = d;
        for (int k = 1; k <= wc; k++) begin
            @(posedge clk); #1;
            check_eq({tag, "_wait"}, 32'(term_of(s)), 32'd0);
        end
        @(posedge clk); #1;
        check_eq({tag, "_term"}, 32'(term_of(s)), 32'(exp_term));
        if (!w) check_eq({tag, "_dat"}, 32'(dout[s]), 32'(exp_dat));
        cyc[s] = 1'b0;
        stb    = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_idle"}, 32'({term_of(s), dout[s]}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cyc = '0;
        stb = 1'b0;
        we  = 1'b0;
        dat = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_term", 32'(term_of(0)), 32'd0);
        check_eq("rst_dat", 32'(dout[0]), 32'd0);
        check_eq("rst_count", 32'(cnt[0]), 32'd0);
        check_eq("rst_empty", 32'(empty[0]), 32'd1);
        check_eq("rst_full", 32'(full[0]), 32'd0);

        // Single write then read
        xfer(0, 1'b1, 8'hA5, 0, 3'b100, 8'h00, "wr_a5");
        check_eq("wr_a5_count", 32'(cnt[0]), 32'd1);
        check_eq("wr_a5_empty", 32'(empty[0]), 32'd0);
        xfer(0, 1'b0, 8'h00, 0, 3'b100, 8'hA5, "rd_a5");
        check_eq("rd_a5_count", 32'(cnt[0]), 32'd0);

        // Fill to full (pointers start at 1, so this wraps), overflow retry, drain in order
        for (int i = 1; i <= 16; i++) xfer(0, 1'b1, 8'(i), 0, 3'b100, 8'h00, "fill");
        check_eq("fill_full", 32'(full[0]), 32'd1);
        check_eq("fill_count", 32'(cnt[0]), 32'd16);
        xfer(0, 1'b1, 8'h11, 0, 3'b001, 8'h00, "wr_full_rty");
        check_eq("wr_full_count", 32'(cnt[0]), 32'd16);
        for (int i = 1; i <= 16; i++) xfer(0, 1'b0, 8'h00, 0, 3'b100, 8'(i), "drain");
        check_eq("drain_empty", 32'(empty[0]), 32'd1);
        check_eq("drain_count", 32'(cnt[0]), 32'd0);

        // Held request: acks at t+1, t+3, t+5
        cyc[0] = 1'b1;
        stb    = 1'b1;
        we     = 1'b1;
        dat    = 8'h77;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check_eq("held_term", 32'(term_of(0)), (k % 2 == 1) ? 32'd4 : 32'd0);
        end
        cyc[0] = 1'b0;
        stb    = 1'b0;
        @(posedge clk); #1;
        check_eq("held_count", 32'(cnt[0]), 32'd3);

        // Read on empty with error termination
        xfer(1, 1'b0, 8'h00, 0, 3'b010, 8'h00, "rd_empty_err");
        check_eq("rd_empty_count", 32'(cnt[1]), 32'd0);

        // Three wait states
        xfer(2, 1'b1, 8'h3C, 3, 3'b100, 8'h00, "wait3_wr");
        check_eq("wait3_count", 32'(cnt[2]), 32'd1);

        // Abort: cyc dropped in cycle t+2
        cyc[2] = 1'b1;
        stb    = 1'b1;
        we     = 1'b1;
        dat    = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        cyc[2] = 1'b0;
        stb    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("abort_term", 32'(term_of(2)), 32'd0);
            @(posedge clk); #1;
        end
        check_eq("abort_count", 32'(cnt[2]), 32'd1);

        // Reset in cycle t+2 of a wait-state transfer
        cyc[2] = 1'b1;
        stb    = 1'b1;
        we     = 1'b1;
        dat    = 8'h66;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        cyc[2] = 1'b0;
        stb    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("rst_mid_term", 32'(term_of(2)), 32'd0);
            @(posedge clk); #1;
        end
        check_eq("rst_mid_count", 32'(cnt[2]), 32'd0);
        check_eq("rst_mid_empty", 32'(empty[2]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
